// File: rtl/ddr2_phy_pkg.sv
// ddr2_phy_pkg: shared state, command-bus types and sizing helpers for the DDR2 lane sequencer
package ddr2_phy_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_PRE,
        WR_BURST,
        WR_POST,
        RD_WAIT,
        RD_BURST
    } state_t;
    typedef struct packed {
        logic cke;
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
        logic odt;
    } cmd_ctl_t;
    localparam int DQ_WIDTH_DEF = 16;
    localparam int DM_WIDTH = DQ_WIDTH_DEF / 8;
    localparam cmd_ctl_t CTL_RST = '{cke: 1'b0, cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, odt: 1'b0};
    function automatic int cnt_width(input int wl, input int rl, input int bl);
        int m;
        m = wl > rl ? wl : rl;
        m = m > bl ? m : bl;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/ddr2_cmd_reg.sv
// ddr2_cmd_reg: registered command/address bank feeding the DDR2 pads
module ddr2_cmd_reg
    import ddr2_phy_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int BA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  cmd_ctl_t              ctl_i,
    input  logic [BA_WIDTH-1:0]   ba_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output cmd_ctl_t              ctl_o,
    output logic [BA_WIDTH-1:0]   ba_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    cmd_ctl_t ctl_q, ctl_d;
    logic [BA_WIDTH-1:0] ba_q, ba_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    always_comb begin
        ctl_d = ctl_i;
        ba_d = ba_i;
        addr_d = addr_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q <= CTL_RST;
            ba_q <= '0;
            addr_q <= '0;
        end else begin
            ctl_q <= ctl_d;
            ba_q <= ba_d;
            addr_q <= addr_d;
        end
    end
    assign ctl_o = ctl_q;
    assign ba_o = ba_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/ddr2_phy_lane_seq.sv
// ddr2_phy_lane_seq: DDR2 pad-side sequencer for command registering, write strobing and read capture
module ddr2_phy_lane_seq
    import ddr2_phy_pkg::*;
#(
    parameter int DQ_WIDTH = DQ_WIDTH_DEF,
    parameter int ADDR_WIDTH = 13,
    parameter int BA_WIDTH = 2,
    parameter int BURST_LEN = 4,
    parameter int WL = 2,
    parameter int RL = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cke_i,
    input  logic                    cs_n_i,
    input  logic                    ras_n_i,
    input  logic                    cas_n_i,
    input  logic                    we_n_i,
    input  logic                    odt_i,
    input  logic [BA_WIDTH-1:0]     ba_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    output logic                    cke_o,
    output logic                    cs_n_o,
    output logic                    ras_n_o,
    output logic                    cas_n_o,
    output logic                    we_n_o,
    output logic                    odt_o,
    output logic [BA_WIDTH-1:0]     ba_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    input  logic                    wr_start,
    input  logic                    rd_start,
    input  logic [DQ_WIDTH-1:0]     wr_data,
    input  logic [DQ_WIDTH/8-1:0]   wr_mask,
    output logic                    wr_data_ack,
    output logic [DQ_WIDTH-1:0]     dq_out,
    output logic [DQ_WIDTH/8-1:0]   dm_out,
    output logic                    dq_oe,
    output logic [DQ_WIDTH/8-1:0]   dqs_out,
    output logic                    dqs_oe,
    input  logic [DQ_WIDTH-1:0]     dq_in,
    output logic                    ri_o,
    output logic [DQ_WIDTH-1:0]     rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    cmd_err
);
    localparam int DMW = DQ_WIDTH / 8;
    localparam int CW = cnt_width(WL, RL, BURST_LEN);
    cmd_ctl_t ctl_in, ctl_out;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DQ_WIDTH-1:0] dq_q, dq_d, rd_q, rd_d;
    logic [DMW-1:0] dm_q, dm_d;
    logic rd_valid_q, rd_valid_d, cmd_err_q, cmd_err_d;
    logic ack, counting;
    assign ctl_in = {cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, odt_i};
    assign {cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o} = ctl_out;
    ddr2_cmd_reg #(.ADDR_WIDTH(ADDR_WIDTH), .BA_WIDTH(BA_WIDTH)) u_cmd_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl_i (ctl_in),
        .ba_i  (ba_i),
        .addr_i(addr_i),
        .ctl_o (ctl_out),
        .ba_o  (ba_o),
        .addr_o(addr_o)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = wr_start ? (WL == 0 ? WR_PRE : WR_WAIT) : (rd_start ? RD_WAIT : IDLE);
            WR_WAIT:  state_d = cnt_q == CW'(WL - 1) ? WR_PRE : WR_WAIT;
            WR_PRE:   state_d = WR_BURST;
            WR_BURST: state_d = cnt_q == CW'(BURST_LEN - 1) ? WR_POST : WR_BURST;
            WR_POST:  state_d = IDLE;
            RD_WAIT:  state_d = cnt_q == CW'(RL - 1) ? RD_BURST : RD_WAIT;
            RD_BURST: state_d = cnt_q == CW'(BURST_LEN - 1) ? IDLE : RD_BURST;
            default:  state_d = IDLE;
        endcase
        counting = state_q inside {WR_WAIT, WR_BURST, RD_WAIT, RD_BURST};
        cnt_d = state_d != state_q ? '0 : (counting ? cnt_q + CW'(1) : cnt_q);
        ack = state_q == WR_PRE || (state_q == WR_BURST && cnt_q != CW'(BURST_LEN - 1));
        dq_d = ack ? wr_data : dq_q;
        dm_d = ack ? wr_mask : dm_q;
        rd_d = state_q == RD_BURST ? dq_in : rd_q;
        rd_valid_d = state_q == RD_BURST;
        cmd_err_d = (wr_start || rd_start) && (state_q != IDLE || (wr_start && rd_start));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dq_q <= '0;
            dm_q <= '0;
            rd_q <= '0;
            rd_valid_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dq_q <= dq_d;
            dm_q <= dm_d;
            rd_q <= rd_d;
            rd_valid_q <= rd_valid_d;
            cmd_err_q <= cmd_err_d;
        end
    end
    assign wr_data_ack = ack;
    assign dq_out = dq_q;
    assign dm_out = dm_q;
    assign dq_oe = state_q == WR_BURST;
    assign dqs_oe = state_q inside {WR_PRE, WR_BURST, WR_POST};
    assign dqs_out = {DMW{state_q == WR_BURST && !cnt_q[0]}};
    assign ri_o = state_q == RD_BURST;
    assign rd_data = rd_q;
    assign rd_valid = rd_valid_q;
    assign busy = state_q != IDLE;
    assign cmd_err = cmd_err_q;
endmodule

// File: tb/tb_ddr2_phy_lane_seq.sv
// tb_ddr2_phy_lane_seq: randomized self-checking bench against a cycle-window reference model
module tb_ddr2_phy_lane_seq;
    localparam int WL = 2;
    localparam int RL = 3;
    localparam int BL = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, sel8;
    logic cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, odt_i;
    logic [1:0] ba_i;
    logic [12:0] addr_i;
    logic wr_start, rd_start;
    logic [15:0] wr_data, dq_in;
    logic [1:0] wr_mask;
    logic cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o;
    logic [1:0] ba_o;
    logic [12:0] addr_o;
    logic ack, dq_oe, dqs_oe, ri_o, rd_valid, busy, cmd_err;
    logic [15:0] dq_out, rd_data;
    logic [1:0] dm_out, dqs_out;
    logic cke8, cs8, ras8, cas8, we8, odt8;
    logic [1:0] ba8;
    logic [12:0] addr8;
    logic ack8, dq_oe8, dqs_oe8, ri8, rd_valid8, busy8, cmd_err8;
    logic [15:0] dq_out8, rd_data8;
    logic [1:0] dm_out8, dqs_out8;
    logic [6:0] ctl_m;
    logic [15:0] dq_m;
    logic [1:0] dm_m, dqs_m;
    int checks = 0;
    int failures = 0;
    assign ctl_m = sel8 ? {ack8, dq_oe8, dqs_oe8, busy8, cmd_err8, rd_valid8, ri8}
                        : {ack, dq_oe, dqs_oe, busy, cmd_err, rd_valid, ri_o};
    assign dq_m = sel8 ? dq_out8 : dq_out;
    assign dm_m = sel8 ? dm_out8 : dm_out;
    assign dqs_m = sel8 ? dqs_out8 : dqs_out;

    ddr2_phy_lane_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cke_i(cke_i), .cs_n_i(cs_n_i), .ras_n_i(ras_n_i), .cas_n_i(cas_n_i), .we_n_i(we_n_i), .odt_i(odt_i),
        .ba_i(ba_i), .addr_i(addr_i),
        .cke_o(cke_o), .cs_n_o(cs_n_o), .ras_n_o(ras_n_o), .cas_n_o(cas_n_o), .we_n_o(we_n_o), .odt_o(odt_o),
        .ba_o(ba_o), .addr_o(addr_o),
        .wr_start(wr_start && !sel8), .rd_start(rd_start && !sel8), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_data_ack(ack), .dq_out(dq_out), .dm_out(dm_out), .dq_oe(dq_oe), .dqs_out(dqs_out), .dqs_oe(dqs_oe),
        .dq_in(dq_in), .ri_o(ri_o), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .cmd_err(cmd_err)
    );

    ddr2_phy_lane_seq #(.WL(0), .BURST_LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .cke_i(cke_i), .cs_n_i(cs_n_i), .ras_n_i(ras_n_i), .cas_n_i(cas_n_i), .we_n_i(we_n_i), .odt_i(odt_i),
        .ba_i(ba_i), .addr_i(addr_i),
        .cke_o(cke8), .cs_n_o(cs8), .ras_n_o(ras8), .cas_n_o(cas8), .we_n_o(we8), .odt_o(odt8),
        .ba_o(ba8), .addr_o(addr8),
        .wr_start(wr_start && sel8), .rd_start(1'b0), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_data_ack(ack8), .dq_out(dq_out8), .dm_out(dm_out8), .dq_oe(dq_oe8), .dqs_out(dqs_out8), .dqs_oe(dqs_oe8),
        .dq_in(dq_in), .ri_o(ri8), .rd_data(rd_data8), .rd_valid(rd_valid8), .busy(busy8), .cmd_err(cmd_err8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cke_i = 1'b0; cs_n_i = 1'b1; ras_n_i = 1'b1; cas_n_i = 1'b1; we_n_i = 1'b1; odt_i = 1'b0;
        ba_i = '0; addr_i = '0;
        wr_start = 1'b0; rd_start = 1'b0; wr_data = '0; wr_mask = '0; dq_in = '0;
    endtask

    task automatic run_write(input string tag, input int wl, input int bl, input logic [15:0] beats [8],
                             input logic [1:0] masks [8], input bit both, input int late_rd);
        for (int k = 0; k <= wl + bl + 2; k++) begin
            int b, o;
            logic [6:0] e;
            logic [1:0] es;
            b = k - wl - 1;
            o = k - wl - 2;
            wr_start = k == 0;
            rd_start = (both && k == 0) || k == late_rd;
            wr_data = (b >= 0 && b < bl) ? beats[b] : 16'($urandom);
            wr_mask = (b >= 0 && b < bl) ? masks[b] : 2'($urandom);
            e = {b >= 0 && b < bl, o >= 0 && o < bl, k >= wl + 1, k >= 1,
                 (both && k == 1) || (late_rd >= 0 && k == late_rd + 1), 1'b0, 1'b0};
            es = {2{o >= 0 && o < bl && o % 2 == 0}};
            checks++;
            if (ctl_m !== e) begin
                failures++;
                $display("FAIL %s ctl k=%0d got=%b exp=%b (ack,dq_oe,dqs_oe,busy,cmd_err,rd_valid,ri)", tag, k, ctl_m, e);
            end
            checks++;
            if (dqs_m !== es) begin
                failures++;
                $display("FAIL %s dqs k=%0d got=%b exp=%b", tag, k, dqs_m, es);
            end
            if (o >= 0 && o < bl) begin
                checks++;
                if ({dq_m, dm_m} !== {beats[o], masks[o]}) begin
                    failures++;
                    $display("FAIL %s dq k=%0d got=%h/%b exp=%h/%b", tag, k, dq_m, dm_m, beats[o], masks[o]);
                end
            end
            tick();
        end
        wr_start = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic run_read(input string tag, input logic [15:0] beats [4]);
        for (int k = 0; k <= RL + BL + 1; k++) begin
            int i, o;
            logic [6:0] e;
            i = k - RL - 1;
            o = k - RL - 2;
            rd_start = k == 0;
            wr_start = 1'b0;
            dq_in = (i >= 0 && i < BL) ? beats[i] : 16'($urandom);
            e = {4'b0000 | 4'(k >= 1 && k <= RL + BL), 1'b0, o >= 0 && o < BL, i >= 0 && i < BL};
            checks++;
            if (ctl_m !== e) begin
                failures++;
                $display("FAIL %s ctl k=%0d got=%b exp=%b (ack,dq_oe,dqs_oe,busy,cmd_err,rd_valid,ri)", tag, k, ctl_m, e);
            end
            if (o >= 0 && o < BL) begin
                checks++;
                if (rd_data !== beats[o]) begin
                    failures++;
                    $display("FAIL %s rd_data k=%0d got=%h exp=%h", tag, k, rd_data, beats[o]);
                end
            end
            tick();
        end
        rd_start = 1'b0;
    endtask

    task automatic rand_write(input string tag, input bit both);
        logic [15:0] beats [8];
        logic [1:0] masks [8];
        foreach (beats[i]) begin
            beats[i] = 16'($urandom);
            masks[i] = 2'($urandom);
        end
        run_write(tag, WL, BL, beats, masks, both, -1);
    endtask

    task automatic rand_read(input string tag);
        logic [15:0] beats [4];
        foreach (beats[i]) beats[i] = 16'($urandom);
        run_read(tag, beats);
    endtask

    task automatic test_reset;
        sel8 = 1'b0;
        idle_inputs();
        cke_i = 1'b1; cs_n_i = 1'b0; addr_i = 13'h0FFF;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o, ba_o, addr_o} !== {6'b011110, 2'b00, 13'h0}) begin
            failures++;
            $display("FAIL reset cmd got=%b exp=%b", {cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o, ba_o, addr_o},
                     {6'b011110, 2'b00, 13'h0});
        end
        checks++;
        if ({ctl_m, dq_m, dm_m, dqs_m, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset data ctl=%b dq=%h dm=%b dqs=%b rd=%h exp all zero", ctl_m, dq_m, dm_m, dqs_m, rd_data);
        end
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({cke_o, cs_n_o, ctl_m} !== {2'b01, 7'b0}) begin
                failures++;
                $display("FAIL idle k=%0d cke/cs_n/ctl got=%b exp=%b", k, {cke_o, cs_n_o, ctl_m}, {2'b01, 7'b0});
            end
        end
        addr_i = 13'h1ABC;
        checks++;
        if (addr_o !== 13'h0) begin
            failures++;
            $display("FAIL addr_early got=%h exp=0000", addr_o);
        end
        tick();
        checks++;
        if (addr_o !== 13'h1ABC) begin
            failures++;
            $display("FAIL addr_latency got=%h exp=1abc", addr_o);
        end
        addr_i = '0;
        tick();
    endtask

    task automatic test_cmd;
        for (int k = 0; k < 10; k++) begin
            logic [20:0] v;
            v = 21'($urandom);
            {cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, odt_i, ba_i, addr_i} = v;
            tick();
            checks++;
            if ({cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o, ba_o, addr_o} !== v) begin
                failures++;
                $display("FAIL cmd k=%0d got=%h exp=%h", k, {cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o, ba_o, addr_o}, v);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write;
        logic [15:0] beats [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [1:0] masks [8] = '{default: 2'b00};
        run_write("write", WL, BL, beats, masks, 1'b0, -1);
    endtask

    task automatic test_read;
        logic [15:0] beats [4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001};
        run_read("read", beats);
    endtask

    task automatic test_conflict;
        logic [15:0] beats [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [1:0] masks [8] = '{default: 2'b00};
        run_write("conflict", WL, BL, beats, masks, 1'b1, 3);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k <= 5; k++) begin
            wr_start = k == 0;
            wr_data = 16'($urandom);
            wr_mask = 2'($urandom);
            if (k == 5) rst_n = 1'b0;
            tick();
        end
        wr_start = 1'b0;
        checks++;
        if (ctl_m !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid ctl got=%b exp=0000000", ctl_m);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (ctl_m !== 7'b0) begin
                failures++;
                $display("FAIL after_reset k=%0d ctl got=%b exp=0000000", k, ctl_m);
            end
        end
        rand_write("post_reset", 1'b0);
    endtask

    task automatic test_wl0;
        logic [15:0] beats [8];
        logic [1:0] masks [8];
        foreach (beats[i]) begin
            beats[i] = 16'($urandom);
            masks[i] = 2'($urandom);
        end
        sel8 = 1'b1;
        run_write("wl0_bl8", 0, 8, beats, masks, 1'b0, -1);
        sel8 = 1'b0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            int gap;
            if ($urandom_range(1, 0) == 1) rand_write("rand_wr", 1'b0);
            else rand_read("rand_rd");
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (ctl_m !== 7'b0) begin
                    failures++;
                    $display("FAIL gap n=%0d ctl got=%b exp=0000000", n, ctl_m);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        rand_write("b2b_wr0", 1'b0);
        rand_write("b2b_wr1", 1'b0);
        rand_read("b2b_rd");
        rand_write("b2b_wr2", 1'b1);
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_write();
        test_read();
        test_conflict();
        test_reset_mid();
        test_wl0();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr2_phy_lane_seq.md
Name: ddr2_phy_lane_seq

Overview:
Parametrised, clocked successor to the fixed 16-bit SSTL18 DDR2 pad interface. It registers the command/address bus and sequences the bidirectional data path: write preamble, burst and postamble with DQS toggling, and read receiver-enable windows with burst capture. It sits between the DDR2 controller core and the SSTL18 pad cells, driving their A, TS and RI controls per lane. Single-data-rate model: one beat per clk.

Parameters:
DQ_WIDTH, 16, data bus width; must be a multiple of 8.
ADDR_WIDTH, 13, address bus width.
BA_WIDTH, 2, bank address width.
BURST_LEN, 4, beats per burst; must be even and at least 2.
WL, 2, cycles from accepted write to preamble; 0 is allowed.
RL, 3, cycles from accepted read to first capture beat; at least 1.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk only
cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, odt_i  in  1 each  command inputs
ba_i  in  BA_WIDTH  bank address
addr_i  in  ADDR_WIDTH  address
cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o  out  1 each  registered command outputs to pads
ba_o  out  BA_WIDTH  registered bank address
addr_o  out  ADDR_WIDTH  registered address
wr_start  in  1  request a write burst
rd_start  in  1  request a read burst
wr_data  in  DQ_WIDTH  write beat
wr_mask  in  DQ_WIDTH/8  per-byte mask for the beat
wr_data_ack  out  1  wr_data/wr_mask consumed this cycle
dq_out  out  DQ_WIDTH  to pad A
dm_out  out  DQ_WIDTH/8  to dm pad A
dq_oe  out  1  output enable for dq and dm; the pad TS input is its inverse
dqs_out  out  DQ_WIDTH/8  per-lane strobe (dqs_n is its complement)
dqs_oe  out  1  output enable for dqs
dq_in  in  DQ_WIDTH  from pad Z
ri_o  out  1  receiver enable
rd_data  out  DQ_WIDTH  captured beat
rd_valid  out  1  rd_data valid
busy  out  1  sequencer not idle
cmd_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: cke_o=0; cs_n_o, ras_n_o, cas_n_o, we_n_o = 1; ba_o, addr_o, odt_o = 0. All data outputs, enables, ack, valid, busy and cmd_err = 0. State = IDLE.
- Command path: every command input is registered, so pad outputs follow inputs with 1-cycle latency, unconditionally.
- FSM states: IDLE, WR_WAIT, WR_PRE, WR_BURST, WR_POST, RD_WAIT, RD_BURST.
- Cycle numbering: c0 is the cycle wr_start or rd_start is sampled high in IDLE.
- Write, state sequence:
  - WR_WAIT for c1..cWL; skipped when WL=0.
  - WR_PRE at cWL+1.
  - WR_BURST for cWL+2..cWL+BURST_LEN+1.
  - WR_POST at cWL+BURST_LEN+2, then IDLE.
- Write, data handshake:
  - wr_data_ack is high for cWL+1..cWL+BURST_LEN, giving exactly BURST_LEN acks.
  - Data and mask sampled in an ack cycle appear on dq_out/dm_out in the next cycle.
- Write, enables and strobe:
  - dqs_oe is high in WR_PRE, WR_BURST and WR_POST.
  - dqs_out = 0 in WR_PRE and WR_POST; in WR_BURST it is 1 on beat 0 and toggles every beat.
  - dq_oe is high only in WR_BURST.
- Read:
  - RD_WAIT for c1..cRL; RD_BURST for cRL+1..cRL+BURST_LEN.
  - ri_o is high only in RD_BURST, and dq_in is sampled each RD_BURST cycle.
  - rd_data/rd_valid are registered, so rd_valid is high for cRL+2..cRL+BURST_LEN+1.
  - dq_oe and dqs_oe stay 0 throughout.
- busy is high in every non-IDLE state. The sequencer is back in IDLE, and ready for a new request, on the cycle after the last WR_POST or RD_BURST cycle.
- Request conflicts:
  - wr_start and rd_start both high in IDLE: the write is accepted and cmd_err pulses.
  - Any start while busy: ignored, and cmd_err pulses the following cycle.
- Reset mid-burst: at the next edge with rst_n low, all enables, ack and valid go to 0 and the state goes to IDLE. No residual beats are produced after reset releases.
- Counters: a single beat/wait counter of width clog2(max(WL, RL, BURST_LEN)+1). It reloads on every state entry and never wraps within a state.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ddr2_phy_pkg:
  - state enum;
  - localparam DM_WIDTH = DQ_WIDTH/8;
  - counter width function;
  - reset-value constants for the command bus.
- Sub-module ddr2_cmd_reg: the parametrised registered command/address bank with its reset values.
- The FSM, DQS generator and read capture stay in the top module.

Test Plan (all with default parameters):
1. Reset, then 5 cycles with rst_n=1 and all inputs 0 → cke_o=0, cs_n_o=1, all enables=0, busy=0. Then drive addr_i=0x1ABC → addr_o=0x1ABC exactly one cycle later.
2. wr_start at c0 with beats 0x1111, 0x2222, 0x3333, 0x4444 and mask 0 →
   - ack at c3..c6;
   - dq_out = those beats at c4..c7, with dq_oe high c4..c7;
   - dqs_out = 11, 00, 11, 00 at c4..c7;
   - dqs_oe high c3..c8;
   - busy low from c9.
3. rd_start at c0 with dq_in = 0xA5A5, 0x5A5A, 0xFFFF, 0x0001 at c4..c7 → ri_o high c4..c7; rd_valid high c5..c8 with the same values in order; dq_oe=0 throughout.
4. wr_start and rd_start together at c0 → write sequence exactly as in scenario 2, cmd_err pulses once, no rd_valid. Then rd_start at c3 → ignored, and cmd_err pulses at c4.
5. rst_n low at c5 of a write → at c6 dq_oe, dqs_oe and busy are 0. No further ack; a new wr_start after release runs a full clean burst.
6. WL=0, BURST_LEN=8 build → WR_PRE at c1, 8 acks at c1..c8, dq_oe high c2..c9, WR_POST at c10.
